// File: rtl/cam_seq_pkg.sv
// Shared definitions for the camera power sequencer: state encoding and
// default cycle constants for a 24 MHz PLL output clock.
package cam_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        LOCK_STAB = 3'd1,
        PWDN_DLY  = 3'd2,
        RST_DLY   = 3'd3,
        INIT_DLY  = 3'd4,
        READY     = 3'd5
    } seq_state_t;

    // 24 MHz: ~43 us lock qualification, 1 ms per pin step, 20 ms SCCB settle
    localparam int LOCK_CYC_DEF = 1024;
    localparam int PWDN_CYC_DEF = 24000;
    localparam int RST_CYC_DEF  = 24000;
    localparam int INIT_CYC_DEF = 480000;
    localparam int CNT_W_DEF    = 20;

    localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/seq_timer.sv
// Shared delay timer: clears to zero, counts while enabled, and flags the
// terminal count (limit-1) against a limit chosen at runtime by the FSM.
module seq_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = en && (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/cam_power_sequencer.sv
// OV5640 power-up sequencer: qualifies PLL lock, releases the fabric reset,
// then steps PWDN, RESETB and an SCCB settle delay. Optional LOCK_LOSS_COUNT_EN
// adds a saturating lock-loss counter output.
module cam_power_sequencer
    import cam_seq_pkg::*;
#(
    parameter int LOCK_CYC = LOCK_CYC_DEF,
    parameter int PWDN_CYC = PWDN_CYC_DEF,
    parameter int RST_CYC  = RST_CYC_DEF,
    parameter int INIT_CYC = INIT_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       sys_rst,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       sccb_ready,
    output logic [2:0] seq_state
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_CYC);
    localparam logic [CNT_W-1:0] PWDN_LIM = CNT_W'(PWDN_CYC);
    localparam logic [CNT_W-1:0] RST_LIM  = CNT_W'(RST_CYC);
    localparam logic [CNT_W-1:0] INIT_LIM = CNT_W'(INIT_CYC);

    seq_state_t       state, state_nxt;
    logic             lk_m, lk_s;
    logic             sys_rst_nxt, cam_pwdn_nxt, cam_rst_n_nxt, sccb_ready_nxt;
    logic             tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0] tmr_lim;
    logic             lock_loss;
    logic             restart_ok;

    assign lock_loss  = (state != WAIT_LOCK) && !lk_s;
    assign restart_ok = restart && (state inside {PWDN_DLY, RST_DLY, INIT_DLY, READY});

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clkin),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_lim),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clkin) begin
        if (rst) begin
            lk_m       <= 1'b0;
            lk_s       <= 1'b0;
            state      <= WAIT_LOCK;
            sys_rst    <= 1'b1;
            cam_pwdn   <= 1'b1;
            cam_rst_n  <= 1'b0;
            sccb_ready <= 1'b0;
        end else begin
            lk_m       <= pll_lock;
            lk_s       <= lk_m;
            state      <= state_nxt;
            sys_rst    <= sys_rst_nxt;
            cam_pwdn   <= cam_pwdn_nxt;
            cam_rst_n  <= cam_rst_n_nxt;
            sccb_ready <= sccb_ready_nxt;
        end
    end

    // Lock loss outranks restart; the timer is cleared on every state entry,
    // including a restart that re-enters PWDN_DLY from PWDN_DLY.
    always_comb begin
        state_nxt      = state;
        sys_rst_nxt    = sys_rst;
        cam_pwdn_nxt   = cam_pwdn;
        cam_rst_n_nxt  = cam_rst_n;
        sccb_ready_nxt = sccb_ready;
        tmr_clr        = 1'b0;
        tmr_en         = 1'b0;
        tmr_lim        = LOCK_LIM;

        if (lock_loss) begin
            state_nxt      = WAIT_LOCK;
            sys_rst_nxt    = 1'b1;
            cam_pwdn_nxt   = 1'b1;
            cam_rst_n_nxt  = 1'b0;
            sccb_ready_nxt = 1'b0;
            tmr_clr        = 1'b1;
        end else if (restart_ok) begin
            state_nxt      = PWDN_DLY;
            cam_pwdn_nxt   = 1'b1;
            cam_rst_n_nxt  = 1'b0;
            sccb_ready_nxt = 1'b0;
            tmr_clr        = 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    tmr_clr = 1'b1;
                    if (lk_s) begin
                        state_nxt = LOCK_STAB;
                    end
                end
                LOCK_STAB: begin
                    tmr_en  = 1'b1;
                    tmr_lim = LOCK_LIM;
                    if (tmr_tc) begin
                        sys_rst_nxt = 1'b0;
                        state_nxt   = PWDN_DLY;
                        tmr_clr     = 1'b1;
                    end
                end
                PWDN_DLY: begin
                    tmr_en  = 1'b1;
                    tmr_lim = PWDN_LIM;
                    if (tmr_tc) begin
                        cam_pwdn_nxt = 1'b0;
                        state_nxt    = RST_DLY;
                        tmr_clr      = 1'b1;
                    end
                end
                RST_DLY: begin
                    tmr_en  = 1'b1;
                    tmr_lim = RST_LIM;
                    if (tmr_tc) begin
                        cam_rst_n_nxt = 1'b1;
                        state_nxt     = INIT_DLY;
                        tmr_clr       = 1'b1;
                    end
                end
                INIT_DLY: begin
                    tmr_en  = 1'b1;
                    tmr_lim = INIT_LIM;
                    if (tmr_tc) begin
                        sccb_ready_nxt = 1'b1;
                        state_nxt      = READY;
                        tmr_clr        = 1'b1;
                    end
                end
                READY: begin
                    tmr_clr = 1'b1;
                end
                default: begin
                    state_nxt = WAIT_LOCK;
                    tmr_clr   = 1'b1;
                end
            endcase
        end
    end

    assign seq_state = state;

`ifdef LOCK_LOSS_COUNT_EN
    always_ff @(posedge clkin) begin
        if (rst) begin
            lock_loss_cnt <= 8'd0;
        end else if (lock_loss && (lock_loss_cnt != LOSS_CNT_MAX)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule
